spi_slave_shifter: RTL and testbench
====================================

SPI_SLAVE_SHIFTER -- requirements
Module: spi_slave_shifter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word length in bits, legal range 4..32.
REQ-002 SHALL have parameter CPOL, default 0: SCLK idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter TX_DUMMY, default all-ones DATA_W: word shifted out on underrun.
REQ-005 SHALL have one clock and asynchronous active-low reset: clk_i  in  1  system clock; rst_n_i  in  1  async active-low reset.
REQ-006 SHALL have sclk_pe_i  in  1  one-cycle pulse, SCLK rising edge, already synchronized.
REQ-007 SHALL have sclk_ne_i  in  1  one-cycle pulse, SCLK falling edge, already synchronized.
REQ-008 SHALL have cs_n_i  in  1  synchronized chip select, active low, level.
REQ-009 SHALL have mosi_i  in  1  synchronized MOSI level.
REQ-010 SHALL have miso_o  out  1  registered MISO bit; miso_oe_o  out  1  high while selected.
REQ-011 SHALL have rx_data_o  out  DATA_W  last received word; rx_valid_o  out  1  one-cycle pulse.
REQ-012 SHALL have tx_data_i  in  DATA_W  next word; tx_valid_i  in  1; tx_ready_o  out  1  (valid/ready).
REQ-013 SHALL have busy_o  out  1  high in SHIFT; underrun_o  out  1; underrun_clr_i  in  1.

Function
REQ-014 Leading edge SHALL be sclk_pe_i when CPOL=0, sclk_ne_i when CPOL=1; trailing edge is the other.
REQ-015 FSM states SHALL be IDLE and SHIFT; IDLE->SHIFT on cs_n_i low; any state->IDLE on cs_n_i high.
REQ-016 Edge pulses SHALL be ignored in IDLE and in the cycle cs_n_i goes high.
REQ-017 Word start (entry to SHIFT, or the cycle after the last bit is sampled while cs_n_i stays low) SHALL load the tx shift register from the holding register if full, else TX_DUMMY.
REQ-018 The first MSB SHALL appear on miso_o the cycle after word start when CPHA=0, and the cycle after the first leading edge when CPHA=1.
REQ-019 Subsequent bits SHALL update miso_o the cycle after each shift edge (trailing for CPHA=0, leading for CPHA=1), MSB first.
REQ-020 mosi_i SHALL be sampled on each sample edge into the rx shift register, MSB first; a bit counter 0..DATA_W-1 wraps to 0 after the last bit.
REQ-021 rx_data_o SHALL update and rx_valid_o SHALL pulse one cycle after the DATA_W-th sample edge; rx_data_o holds until the next complete word.
REQ-022 tx_ready_o SHALL equal holding-register-empty; transfer occurs when tx_valid_i and tx_ready_o are both high; consumption at word start empties it.
REQ-023 Load and consumption are mutually exclusive by construction; a word start with an empty holding register is an underrun.
REQ-024 cs_n_i high mid-word SHALL discard the partial word (no rx_valid_o), clear the counter, drive miso_oe_o low, and preserve the holding register.
REQ-025 miso_oe_o SHALL be high exactly while in SHIFT; miso_o SHALL be 0 in IDLE.

Reset
REQ-026 While rst_n_i is low: state IDLE, counter 0, miso_o 0, miso_oe_o 0, rx_data_o 0, rx_valid_o 0, busy_o 0, underrun_o 0, holding register empty, tx_ready_o 1.
REQ-027 Reset asserted mid-word SHALL abandon the word; the first word after release SHALL be received correctly.

Configuration
REQ-028 With SPI_SLAVE_UNDERRUN_EN defined, underrun_o SHALL be a sticky flag set on underrun and cleared by an underrun_clr_i pulse; set SHALL win over a simultaneous clear.
REQ-029 Without SPI_SLAVE_UNDERRUN_EN, underrun_o SHALL be constant 0, underrun_clr_i SHALL be ignored, and TX_DUMMY behaviour SHALL be unchanged.

Structure
REQ-030 spi_pkg SHALL hold the FSM state enum, CPOL/CPHA mode typedef and the default dummy-word constant.
REQ-031 One sub-module SHALL be used: spi_tx_hold (DATA_W holding register with valid/ready and consume strobe).

Verification
REQ-032 Mode 0, tx 0xA5 preloaded, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C with rx_valid_o one cycle after the 8th rising pulse.
REQ-033 No tx word loaded, master sends 0x00 -> miso 0xFF; underrun_o=1 until underrun_clr_i (macro on); underrun_o stays 0 (macro off).
REQ-034 cs_n_i high after 4 bits -> no rx_valid_o, miso_oe_o=0; next full word 0x81 -> rx_data_o=0x81.
REQ-035 Mode 3 (CPOL=1, CPHA=1), two back-to-back words 0x12, 0x34 with cs_n_i held low and tx 0xC3 loaded between -> two rx_valid_o pulses with 0x12 then 0x34, second miso word 0xC3.
REQ-036 rst_n_i pulsed low mid-word -> all outputs at reset values within the same cycle; subsequent word 0x5A -> received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave shifter.
//   spi_state_e      : FSM states (IDLE, SHIFT)
//   spi_mode_e       : {CPOL, CPHA} mode encoding, with decode helpers
//   TX_DUMMY_DEFAULT : all-ones word sent when software has nothing queued
package spi_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  // Encoded as {CPOL, CPHA}.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  localparam logic [31:0] TX_DUMMY_DEFAULT = '1;

  function automatic spi_mode_e make_mode(input int cpol, input int cpha);
    return spi_mode_e'({cpol != 0, cpha != 0});
  endfunction

  // 1 -> idle-high SCLK, so the leading edge is the falling edge.
  function automatic logic mode_cpol(input spi_mode_e m);
    return m[1];
  endfunction

  // 1 -> sample on the trailing edge, shift on the leading edge.
  function automatic logic mode_cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_slave_shifter_if.sv
// Bus bundle between the SPI slave shifter and its surroundings.
//   SPI side : sclk_pe_i / sclk_ne_i edge pulses, cs_n_i, mosi_i, miso_o, miso_oe_o
//   RX side  : rx_data_o, rx_valid_o
//   TX side  : tx_data_i, tx_valid_i, tx_ready_o (valid/ready)
//   Status   : busy_o, underrun_o, underrun_clr_i
// Modport slave is taken by the shifter, master by whoever drives it.
interface spi_slave_shifter_if #(
  parameter int DATA_W = 8
);
  logic              sclk_pe_i;
  logic              sclk_ne_i;
  logic              cs_n_i;
  logic              mosi_i;
  logic              miso_o;
  logic              miso_oe_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic              busy_o;
  logic              underrun_o;
  logic              underrun_clr_i;

  modport slave (
    input  sclk_pe_i, sclk_ne_i, cs_n_i, mosi_i, tx_data_i, tx_valid_i, underrun_clr_i,
    output miso_o, miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o, busy_o, underrun_o
  );

  modport master (
    output sclk_pe_i, sclk_ne_i, cs_n_i, mosi_i, tx_data_i, tx_valid_i, underrun_clr_i,
    input  miso_o, miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o, busy_o, underrun_o
  );
endinterface

// File: rtl/spi_tx_hold.sv
// One-word transmit holding register.
//   tx_data_i/tx_valid_i/tx_ready_o : valid/ready write port, ready = empty
//   consume_i                       : word-start strobe, empties a full register
//   full_o/data_o                   : contents offered to the shift register
// A load needs the register empty and a consume needs it full, so the two
// can never happen in the same cycle.
module spi_tx_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic              consume_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every *_d gets its default first so no path can infer a latch.
    full_d = full_q;
    data_d = data_q;
    if (!full_q && tx_valid_i) begin
      full_d = 1'b1;
      data_d = tx_data_i;
    end else if (full_q && consume_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop in the design samples pre-edge values.
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign tx_ready_o = ~full_q;
  assign full_o     = full_q;
  assign data_o     = data_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave shift engine working from pre-synchronized SCLK edge pulses.
//   clk_i, rst_n_i : system clock, asynchronous active-low reset
//   bus (slave)    : SPI pins, received-word output, transmit valid/ready
//                    input, busy and underrun status (see spi_slave_shifter_if)
// Optional feature: define SPI_SLAVE_UNDERRUN_EN for a sticky underrun_o flag;
// otherwise underrun_o is tied low and underrun_clr_i is ignored.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              CPOL     = 0,
  parameter int              CPHA     = 0,
  parameter logic [DATA_W-1:0] TX_DUMMY = TX_DUMMY_DEFAULT[DATA_W-1:0]
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  spi_slave_shifter_if.slave  bus
);

  localparam spi_mode_e         MODE     = make_mode(CPOL, CPHA);
  localparam bit                LEAD_NE  = mode_cpol(MODE);
  localparam bit                CPHA1    = mode_cpha(MODE);
  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              last_q, last_d;   // last bit sampled last cycle

  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic              word_start;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data, tx_word;

  assign lead_edge   = LEAD_NE ? bus.sclk_ne_i : bus.sclk_pe_i;
  assign trail_edge  = LEAD_NE ? bus.sclk_pe_i : bus.sclk_ne_i;
  assign sample_edge = CPHA1 ? trail_edge : lead_edge;
  assign shift_edge  = CPHA1 ? lead_edge  : trail_edge;
  assign tx_word     = hold_full ? hold_data : TX_DUMMY;

  spi_tx_hold #(.DATA_W(DATA_W)) u_tx_hold (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .tx_data_i  (bus.tx_data_i),
    .tx_valid_i (bus.tx_valid_i),
    .tx_ready_o (bus.tx_ready_o),
    .consume_i  (word_start),
    .full_o     (hold_full),
    .data_o     (hold_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
    last_d     = 1'b0;
    word_start = 1'b0;

    if (bus.cs_n_i) begin
      // Deselect wins over any edge in the same cycle; partial word dropped.
      state_d = ST_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_SHIFT;
      word_start = 1'b1;
    end else begin
      word_start = last_q;
      if (sample_edge) begin
        rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.mosi_i};
        if (cnt_q == LAST_BIT) begin
          cnt_d      = '0;
          rx_data_d  = {rx_sr_q[DATA_W-2:0], bus.mosi_i};
          rx_valid_d = 1'b1;
          last_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // In CPHA=0 the trailing edge after the last sample belongs to the
      // finished word; the next MSB is already out, so it must not shift.
      if (shift_edge && (CPHA1 || cnt_q != '0)) begin
        miso_d  = tx_sr_q[DATA_W-1];
        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
      end
    end

    if (word_start) begin
      if (CPHA1) begin
        tx_sr_d = tx_word;
      end else begin
        // CPHA=0 presents the MSB before the first leading edge.
        miso_d  = tx_word[DATA_W-1];
        tx_sr_d = {tx_word[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      last_q     <= last_d;
    end
  end

  assign bus.miso_o     = miso_q;
  assign bus.miso_oe_o  = (state_q == ST_SHIFT);
  assign bus.busy_o     = (state_q == ST_SHIFT);
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // Set has priority over a clear arriving in the same cycle.
  assign underrun_d = (underrun_q & ~bus.underrun_clr_i) | (word_start & ~hold_full);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) underrun_q <= 1'b0;
    else          underrun_q <= underrun_d;
  end

  assign bus.underrun_o = underrun_q;
`else
  assign bus.underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a mode-0 and a mode-3 instance share
// one stimulus set; dsel routes stimulus to one of them and idles the other.
`timescale 1ns/1ps
module tb_spi_slave_shifter;

`ifdef SPI_SLAVE_UNDERRUN_EN
  localparam logic UR_EN = 1'b1;
`else
  localparam logic UR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       dsel, pe, ne, cs_n, mosi, tx_valid, ur_clr;
  logic [7:0] tx_data;
  int         total = 0, passed = 0;
  int         vcnt0 = 0, vcnt3 = 0;
  logic [7:0] sw;
  logic       vld;

  spi_slave_shifter_if #(.DATA_W(8)) bus0 ();
  spi_slave_shifter_if #(.DATA_W(8)) bus3 ();

  spi_slave_shifter #(.DATA_W(8), .CPOL(0), .CPHA(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus0)
  );
  spi_slave_shifter #(.DATA_W(8), .CPOL(1), .CPHA(1)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus3)
  );

  assign bus0.sclk_pe_i      = dsel ? 1'b0 : pe;
  assign bus0.sclk_ne_i      = dsel ? 1'b0 : ne;
  assign bus0.cs_n_i         = dsel ? 1'b1 : cs_n;
  assign bus0.mosi_i         = mosi;
  assign bus0.tx_data_i      = tx_data;
  assign bus0.tx_valid_i     = dsel ? 1'b0 : tx_valid;
  assign bus0.underrun_clr_i = dsel ? 1'b0 : ur_clr;
  assign bus3.sclk_pe_i      = dsel ? pe : 1'b0;
  assign bus3.sclk_ne_i      = dsel ? ne : 1'b0;
  assign bus3.cs_n_i         = dsel ? cs_n : 1'b1;
  assign bus3.mosi_i         = mosi;
  assign bus3.tx_data_i      = tx_data;
  assign bus3.tx_valid_i     = dsel ? tx_valid : 1'b0;
  assign bus3.underrun_clr_i = dsel ? ur_clr : 1'b0;

  logic       obs_miso, obs_oe, obs_valid, obs_ready, obs_busy, obs_ur;
  logic [7:0] obs_rx;
  assign obs_miso  = dsel ? bus3.miso_o     : bus0.miso_o;
  assign obs_oe    = dsel ? bus3.miso_oe_o  : bus0.miso_oe_o;
  assign obs_valid = dsel ? bus3.rx_valid_o : bus0.rx_valid_o;
  assign obs_ready = dsel ? bus3.tx_ready_o : bus0.tx_ready_o;
  assign obs_busy  = dsel ? bus3.busy_o     : bus0.busy_o;
  assign obs_ur    = dsel ? bus3.underrun_o : bus0.underrun_o;
  assign obs_rx    = dsel ? bus3.rx_data_o  : bus0.rx_data_o;

  always @(negedge clk) begin
    if (bus0.rx_valid_o === 1'b1) vcnt0++;
    if (bus3.rx_valid_o === 1'b1) vcnt3++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the DUT sees the pulse at exactly one posedge.
  task automatic pulse_edge(input logic is_pe);
    if (is_pe) pe = 1'b1; else ne = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    ne = 1'b0;
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic clear_ur();
    ur_clr = 1'b1;
    @(negedge clk);
    ur_clr = 1'b0;
  endtask

  // Master side of nbits bits, MSB first; miso captured just before each
  // sample edge, rx_valid captured the cycle after the 8th sample edge.
  task automatic xfer(input logic [7:0] mw, input logic cpol, input logic cpha,
                      input int nbits, output logic [7:0] miso_w, output logic v);
    logic lead_pe;
    lead_pe = ~cpol;
    miso_w  = '0;
    v       = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mw[7-i];
        idle(2);
        miso_w = {miso_w[6:0], obs_miso};
        pulse_edge(lead_pe);
        if (i == 7) v = obs_valid;
        idle(2);
        pulse_edge(~lead_pe);
      end else begin
        pulse_edge(lead_pe);
        idle(2);
        mosi = mw[7-i];
        miso_w = {miso_w[6:0], obs_miso};
        pulse_edge(~lead_pe);
        if (i == 7) v = obs_valid;
        idle(2);
      end
    end
  endtask

  initial begin
    int v0;
    rst_n = 1'b0; dsel = 1'b0; pe = 1'b0; ne = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; ur_clr = 1'b0; tx_data = '0;

    // Reset values
    idle(2);
    check("rst_miso", obs_miso, 0);
    check("rst_oe", obs_oe, 0);
    check("rst_rx_data", obs_rx, 8'h00);
    check("rst_rx_valid", obs_valid, 0);
    check("rst_busy", obs_busy, 0);
    check("rst_underrun", obs_ur, 0);
    check("rst_tx_ready", obs_ready, 1);
    check("rst_tx_ready_m3", bus3.tx_ready_o, 1);
    rst_n = 1'b1;
    idle(2);

    // Mode 0: tx 0xA5 preloaded, master sends 0x3C
    load_tx(8'hA5);
    check("m0_ready_after_load", obs_ready, 0);
    cs_n = 1'b0;
    idle(1);
    check("m0_oe_selected", obs_oe, 1);
    check("m0_busy_selected", obs_busy, 1);
    check("m0_first_msb", obs_miso, 1);
    check("m0_ready_after_consume", obs_ready, 1);
    xfer(8'h3C, 1'b0, 1'b0, 8, sw, vld);
    check("m0_miso_word", sw, 8'hA5);
    check("m0_valid_timing", vld, 1);
    check("m0_rx_data", obs_rx, 8'h3C);
    check("m0_valid_one_cycle", obs_valid, 0);
    check("m0_next_dummy_msb", obs_miso, 1);
    check("m0_underrun_next", obs_ur, UR_EN);
    cs_n = 1'b1;
    idle(1);
    check("m0_oe_deselect", obs_oe, 0);
    check("m0_miso_idle", obs_miso, 0);
    check("m0_busy_idle", obs_busy, 0);
    clear_ur();
    check("m0_underrun_cleared", obs_ur, 0);

    // Underrun: nothing queued, clear held during the underrun (set wins)
    cs_n = 1'b0; ur_clr = 1'b1;
    idle(1);
    ur_clr = 1'b0;
    check("ur_set_wins", obs_ur, UR_EN);
    xfer(8'h00, 1'b0, 1'b0, 8, sw, vld);
    check("ur_miso_dummy", sw, 8'hFF);
    check("ur_rx_data", obs_rx, 8'h00);
    check("ur_valid", vld, 1);
    cs_n = 1'b1;
    idle(3);
    check("ur_sticky", obs_ur, UR_EN);
    clear_ur();
    check("ur_clear", obs_ur, 0);

    // Abort after 4 bits; holding register survives the abort
    cs_n = 1'b0;
    idle(1);
    load_tx(8'h96);
    check("ab_ready_loaded", obs_ready, 0);
    v0 = vcnt0;
    xfer(8'hF0, 1'b0, 1'b0, 4, sw, vld);
    cs_n = 1'b1;
    idle(1);
    check("ab_oe_low", obs_oe, 0);
    check("ab_miso_low", obs_miso, 0);
    check("ab_hold_kept", obs_ready, 0);
    idle(2);
    check("ab_no_valid", vcnt0, v0);
    check("ab_rx_unchanged", obs_rx, 8'h00);
    cs_n = 1'b0;
    idle(1);
    check("ab_next_msb", obs_miso, 1);
    xfer(8'h81, 1'b0, 1'b0, 8, sw, vld);
    check("ab_miso_word", sw, 8'h96);
    check("ab_rx_data", obs_rx, 8'h81);
    cs_n = 1'b1;
    idle(1);
    clear_ur();

    // Mode 3: back-to-back 0x12, 0x34; 0xC3 queued during the first word
    dsel = 1'b1;
    idle(1);
    load_tx(8'h69);
    cs_n = 1'b0;
    idle(1);
    check("m3_oe", obs_oe, 1);
    check("m3_miso_before_lead", obs_miso, 0);
    load_tx(8'hC3);
    check("m3_ready_c3", obs_ready, 0);
    xfer(8'h12, 1'b1, 1'b1, 8, sw, vld);
    check("m3_miso_w1", sw, 8'h69);
    check("m3_valid_w1", vld, 1);
    check("m3_rx_w1", obs_rx, 8'h12);
    check("m3_c3_consumed", obs_ready, 1);
    xfer(8'h34, 1'b1, 1'b1, 8, sw, vld);
    check("m3_miso_w2", sw, 8'hC3);
    check("m3_valid_w2", vld, 1);
    check("m3_rx_w2", obs_rx, 8'h34);
    cs_n = 1'b1;
    idle(2);
    check("m3_valid_count", vcnt3, 2);
    check("m3_underrun", obs_ur, UR_EN);
    clear_ur();
    dsel = 1'b0;
    idle(1);

    // Reset mid-word, then a clean word
    cs_n = 1'b0;
    idle(1);
    xfer(8'hAA, 1'b0, 1'b0, 4, sw, vld);
    rst_n = 1'b0; cs_n = 1'b1;
    #1;
    check("rm_miso", obs_miso, 0);
    check("rm_oe", obs_oe, 0);
    check("rm_busy", obs_busy, 0);
    check("rm_rx_data", obs_rx, 8'h00);
    check("rm_underrun", obs_ur, 0);
    check("rm_ready", obs_ready, 1);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    load_tx(8'h0F);
    cs_n = 1'b0;
    idle(1);
    check("rm_first_msb", obs_miso, 0);
    xfer(8'h5A, 1'b0, 1'b0, 8, sw, vld);
    check("rm_miso_word", sw, 8'h0F);
    check("rm_valid", vld, 1);
    check("rm_rx_data_after", obs_rx, 8'h5A);
    cs_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
